// File: rtl/na_wb_arbiter_if.sv
// Bus bundle between the NA requesters, the arbiter and the NI Wishbone port.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface na_wb_arbiter_if #(
  parameter int NUM_REQ        = 2,
  parameter int NOC_FLIT_WIDTH = 32
);
  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0]                enable;
  logic [NUM_REQ*32-1:0]             s_adr_i;
  logic [NUM_REQ*NOC_FLIT_WIDTH-1:0] s_dat_i;
  logic [NUM_REQ-1:0]                s_we_i;
  logic [NUM_REQ-1:0]                s_stb_i;
  logic [NUM_REQ-1:0]                s_cyc_i;
  logic [NUM_REQ-1:0]                s_ack_o;
  logic [NUM_REQ-1:0]                s_err_o;
  logic [NOC_FLIT_WIDTH-1:0]         s_dat_o;
  logic [31:0]                       wb_adr_o;
  logic [NOC_FLIT_WIDTH-1:0]         wb_dat_o;
  logic                              wb_we_o;
  logic                              wb_stb_o;
  logic                              wb_cyc_o;
  logic                              wb_ack_i;
  logic                              wb_err_i;
  logic [NOC_FLIT_WIDTH-1:0]         wb_dat_i;

  modport master (
    input  req, s_adr_i, s_dat_i, s_we_i, s_stb_i, s_cyc_i,
    input  wb_ack_i, wb_err_i, wb_dat_i,
    output enable, s_ack_o, s_err_o, s_dat_o,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output req, s_adr_i, s_dat_i, s_we_i, s_stb_i, s_cyc_i,
    output wb_ack_i, wb_err_i, wb_dat_i,
    input  enable, s_ack_o, s_err_o, s_dat_o,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/na_wb_arbiter.sv
// Round-robin arbiter sharing the NI Wishbone master port between NA units,
// with a watchdog that errors out cycles the NI never acknowledges.
//
// state   | meaning
// IDLE    | no grant, pick next requester at/after the pointer
// GRANT   | one requester owns the Wishbone port
// RELEASE | one idle bus cycle after a grant ends
module na_wb_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int TIMEOUT        = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  na_wb_arbiter_if.master      bus,
  output logic                 timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        ptr, ptr_nxt, gnt, gnt_nxt, sel;
  logic                 found;
  logic [NUM_REQ-1:0]   sel_oh, enable_q, enable_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 g_req, g_cyc, g_stb, g_we;
  logic [31:0]          g_adr;
  logic [NOC_FLIT_WIDTH-1:0] g_dat;
  logic                 waiting, expire;

  // Lowest set bit at or above the pointer wins; otherwise lowest below it.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req[i] && (i < int'(ptr))) begin
        sel   = PW'(i);
        found = 1'b1;
      end
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req[i] && (i >= int'(ptr))) begin
        sel   = PW'(i);
        found = 1'b1;
      end
    for (int i = 0; i < NUM_REQ; i++)
      sel_oh[i] = (sel == PW'(i));
  end

  // enable_q is zero outside GRANT, so the AND-OR mux idles the bus by itself.
  always_comb begin
    g_adr = '0;
    g_dat = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (enable_q[i]) begin
        g_adr = g_adr | bus.s_adr_i[32*i +: 32];
        g_dat = g_dat | bus.s_dat_i[NOC_FLIT_WIDTH*i +: NOC_FLIT_WIDTH];
      end
  end

  assign g_req = |(bus.req & enable_q);
  assign g_cyc = |(bus.s_cyc_i & enable_q);
  assign g_stb = |(bus.s_stb_i & enable_q);
  assign g_we  = |(bus.s_we_i & enable_q);

  assign waiting = (state == GRANT) & g_cyc & g_stb & ~bus.wb_ack_i & ~bus.wb_err_i;
  assign expire  = waiting & (cnt == CNT_LAST);

  always_comb begin
    cnt_nxt = '0;
    if (waiting && !expire)
      cnt_nxt = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    enable_nxt = enable_q;
    ptr_nxt    = ptr;
    gnt_nxt    = gnt;
    case (state)
      IDLE:
        if (found) begin
          gnt_nxt    = sel;
          enable_nxt = sel_oh;
          state_nxt  = GRANT;
        end
      GRANT:
        if (!g_req && !g_cyc) begin
          enable_nxt = '0;
          ptr_nxt    = (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + PW'(1);
          state_nxt  = RELEASE;
        end
      RELEASE:
        state_nxt = IDLE;
      default: begin
        enable_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      enable_q <= '0;
      cnt      <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      enable_q <= enable_nxt;
      cnt      <= cnt_nxt;
      timeout  <= expire;
    end
  end

  assign bus.enable   = enable_q;
  assign bus.wb_adr_o = g_adr;
  assign bus.wb_dat_o = g_dat;
  assign bus.wb_we_o  = g_we;
  assign bus.wb_cyc_o = g_cyc & ~expire;
  assign bus.wb_stb_o = g_stb & ~expire;
  assign bus.s_ack_o  = enable_q & {NUM_REQ{bus.wb_ack_i}};
  assign bus.s_err_o  = enable_q & {NUM_REQ{bus.wb_err_i | expire}};
  assign bus.s_dat_o  = bus.wb_dat_i;

endmodule

// File: tb/tb_na_wb_arbiter.sv
// Self-checking bench for na_wb_arbiter: per-scenario tasks plus a scoreboard
// of expected Wishbone beats compared when the NI acknowledges them.
module tb_na_wb_arbiter;
  localparam int NR = 2;
  localparam int W  = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic timeout;
  int   checks = 0;
  int   errors = 0;
  int   tcount = 0;

  typedef struct packed {
    logic [31:0]  adr;
    logic [W-1:0] dat;
    logic         we;
  } xfer_t;
  xfer_t exp_q[$];

  always #5 clk = ~clk;

  na_wb_arbiter_if #(.NUM_REQ(NR), .NOC_FLIT_WIDTH(W)) bus ();
  na_wb_arbiter #(.NUM_REQ(NR), .NOC_FLIT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .timeout(timeout));

  always @(negedge clk) begin
    xfer_t got, e;
    if (timeout) tcount++;
    if (rst && bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
      got = '{adr: bus.wb_adr_o, dat: bus.wb_dat_o, we: bus.wb_we_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected adr=%h dat=%h we=%b with nothing expected", got.adr, got.dat, got.we);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_xfer got adr=%h dat=%h we=%b exp adr=%h dat=%h we=%b",
                   got.adr, got.dat, got.we, e.adr, e.dat, e.we);
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.req = '0; bus.s_cyc_i = '0; bus.s_stb_i = '0; bus.s_we_i = '0;
    bus.s_adr_i = '0; bus.s_dat_i = '0;
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic set_m(input logic r, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [W-1:0] dat);
    bus.s_cyc_i[r] = cyc;
    bus.s_stb_i[r] = stb;
    bus.s_we_i[r]  = we;
    if (r) begin bus.s_adr_i[63:32] = adr; bus.s_dat_i[63:32] = dat; end
    else   begin bus.s_adr_i[31:0]  = adr; bus.s_dat_i[31:0]  = dat; end
  endtask

  // One acknowledged beat; cyc is left high so the packet continues.
  task automatic beat(input logic r, input logic [31:0] adr, input logic [W-1:0] dat, input logic we);
    set_m(r, 1'b1, 1'b1, we, adr, dat);
    bus.wb_ack_i = 1'b1;
    exp_q.push_back('{adr: adr, dat: dat, we: we});
    step();
    bus.wb_ack_i = 1'b0;
    bus.s_stb_i[r] = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b0;
    bus.req = 2'b11;
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = 1'b1;
    step(2);
    checks++; if (bus.enable !== 2'b00) begin errors++; $display("FAIL reset_enable got=%b exp=00", bus.enable); end
    checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== '0) begin
      errors++; $display("FAIL reset_wb_out got cyc=%b stb=%b adr=%h exp all zero", bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o); end
    checks++; if ({bus.s_ack_o, bus.s_err_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ack_err got ack=%b err=%b exp 00/00", bus.s_ack_o, bus.s_err_o); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    idle_all();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    step(3);
    bus.req[0] = 1'b1;
    checks++; if (bus.enable !== 2'b00) begin errors++; $display("FAIL single_pre_grant enable=%b exp=00", bus.enable); end
    step();
    checks++; if (bus.enable !== 2'b01) begin errors++; $display("FAIL single_grant enable=%b exp=01", bus.enable); end
    set_m(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hCAFE0001);
    #1;
    checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== {3'b111, 32'h10, 32'hCAFE0001}) begin
      errors++; $display("FAIL single_wb_pass got adr=%h dat=%h cyc/stb/we=%b%b%b exp 00000010 cafe0001 111",
                         bus.wb_adr_o, bus.wb_dat_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o); end
    bus.wb_ack_i = 1'b1;
    exp_q.push_back('{adr: 32'h10, dat: 32'hCAFE0001, we: 1'b1});
    #1;
    checks++; if (bus.s_ack_o !== 2'b01) begin errors++; $display("FAIL single_ack got=%b exp=01", bus.s_ack_o); end
    step();
    bus.wb_ack_i = 1'b0;
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    bus.wb_dat_i = 32'h12345678;
    bus.wb_ack_i = 1'b1;
    exp_q.push_back('{adr: 32'h14, dat: 32'h0, we: 1'b0});
    #1;
    checks++; if (bus.s_dat_o !== 32'h12345678) begin errors++; $display("FAIL single_rdata got=%h exp=12345678", bus.s_dat_o); end
    step();
    bus.wb_ack_i = 1'b0;
    bus.req[0] = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++; if ({bus.enable, bus.wb_cyc_o} !== 3'b000) begin
      errors++; $display("FAIL single_release got enable=%b cyc=%b exp 00/0", bus.enable, bus.wb_cyc_o); end
    bus.req[0] = 1'b1;
    step();
    checks++; if (bus.enable !== 2'b00) begin errors++; $display("FAIL single_release_gap enable=%b exp=00", bus.enable); end
    step();
    checks++; if (bus.enable !== 2'b01) begin errors++; $display("FAIL single_regrant enable=%b exp=01", bus.enable); end
    idle_all();
    step(3);
  endtask

  task automatic test_contention();
    do_reset();
    bus.req = 2'b11;
    step();
    checks++; if (bus.enable !== 2'b01) begin errors++; $display("FAIL cont_first enable=%b exp=01", bus.enable); end
    beat(1'b0, 32'h100, 32'hA0, 1'b1);
    bus.req[0] = 1'b0;
    bus.s_cyc_i[0] = 1'b0;
    step();
    checks++; if (bus.enable !== 2'b00) begin errors++; $display("FAIL cont_release0 enable=%b exp=00", bus.enable); end
    bus.req[0] = 1'b1;
    step(2);
    checks++; if (bus.enable !== 2'b10) begin errors++; $display("FAIL cont_rr_second enable=%b exp=10", bus.enable); end
    beat(1'b1, 32'h200, 32'hB0, 1'b1);
    bus.req[1] = 1'b0;
    bus.s_cyc_i[1] = 1'b0;
    step(3);
    checks++; if (bus.enable !== 2'b01) begin errors++; $display("FAIL cont_rr_back enable=%b exp=01", bus.enable); end
    idle_all();
    step(3);
  endtask

  task automatic test_hold();
    do_reset();
    bus.req = 2'b01;
    step();
    set_m(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD0000, 32'h55);
    bus.req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({bus.enable, bus.wb_stb_o} !== 3'b010) begin
        errors++; $display("FAIL hold_cycle%0d got enable=%b stb=%b exp 01/0", k, bus.enable, bus.wb_stb_o); end
    end
    bus.s_cyc_i[0] = 1'b0;
    step();
    checks++; if (bus.enable !== 2'b00) begin errors++; $display("FAIL hold_release enable=%b exp=00", bus.enable); end
    step(2);
    checks++; if ({bus.enable, bus.wb_stb_o, bus.wb_adr_o} !== {3'b101, 32'hDEAD0000}) begin
      errors++; $display("FAIL hold_next got enable=%b stb=%b adr=%h exp 10/1/dead0000", bus.enable, bus.wb_stb_o, bus.wb_adr_o); end
    idle_all();
    step(3);
  endtask

  task automatic test_watchdog();
    do_reset();
    tcount = 0;
    bus.req[0] = 1'b1;
    step();
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int k = 1; k < TO; k++) begin
      #1;
      checks++; if ({bus.s_err_o, bus.wb_stb_o} !== 3'b001) begin
        errors++; $display("FAIL wd_wait%0d got err=%b stb=%b exp 00/1", k, bus.s_err_o, bus.wb_stb_o); end
      step();
    end
    checks++; if ({bus.s_err_o, bus.wb_cyc_o, bus.wb_stb_o, timeout} !== 5'b01000) begin
      errors++; $display("FAIL wd_expire got err=%b cyc=%b stb=%b tmo=%b exp 01/0/0/0",
                         bus.s_err_o, bus.wb_cyc_o, bus.wb_stb_o, timeout); end
    step();
    checks++; if ({timeout, bus.s_err_o, bus.enable, bus.wb_stb_o} !== 6'b100011) begin
      errors++; $display("FAIL wd_pulse got tmo=%b err=%b enable=%b stb=%b exp 1/00/01/1",
                         timeout, bus.s_err_o, bus.enable, bus.wb_stb_o); end
    bus.s_stb_i[0] = 1'b0;
    step();
    bus.s_stb_i[0] = 1'b1;
    step(TO - 1);
    bus.wb_ack_i = 1'b1;
    exp_q.push_back('{adr: 32'h40, dat: 32'h0, we: 1'b0});
    #1;
    checks++; if ({bus.s_err_o, bus.s_ack_o, bus.wb_stb_o} !== 5'b00011) begin
      errors++; $display("FAIL wd_ack_wins got err=%b ack=%b stb=%b exp 00/01/1", bus.s_err_o, bus.s_ack_o, bus.wb_stb_o); end
    step();
    bus.wb_ack_i = 1'b0;
    bus.s_stb_i[0] = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_ack_no_tmo got=%b exp=0", timeout); end
    step();
    checks++; if (tcount !== 1) begin errors++; $display("FAIL wd_pulse_count got=%0d exp=1", tcount); end
    idle_all();
    step(3);
  endtask

  task automatic test_err_pass();
    do_reset();
    bus.req = 2'b10;
    step();
    checks++; if (bus.enable !== 2'b10) begin errors++; $display("FAIL err_grant enable=%b exp=10", bus.enable); end
    set_m(1'b0, 1'b1, 1'b1, 1'b1, 32'h900, 32'h99);
    beat(1'b1, 32'h300, 32'h11, 1'b1);
    set_m(1'b1, 1'b1, 1'b1, 1'b1, 32'h304, 32'h22);
    bus.wb_err_i = 1'b1;
    #1;
    checks++; if ({bus.s_err_o, bus.s_ack_o} !== 4'b1000) begin
      errors++; $display("FAIL err_route got err=%b ack=%b exp 10/00", bus.s_err_o, bus.s_ack_o); end
    step();
    bus.wb_err_i = 1'b0;
    bus.s_stb_i[1] = 1'b0;
    checks++; if (bus.enable !== 2'b10) begin errors++; $display("FAIL err_keep_grant enable=%b exp=10", bus.enable); end
    idle_all();
    step(3);
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 2'b01;
    step();
    beat(1'b0, 32'h400, 32'h66, 1'b1);
    bus.req = 2'b00;
    bus.s_cyc_i[0] = 1'b0;
    step(2);
    bus.req = 2'b10;
    step();
    set_m(1'b1, 1'b1, 1'b1, 1'b1, 32'h500, 32'h77);
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({bus.enable, bus.wb_cyc_o, bus.wb_stb_o} !== 4'b0000) begin
      errors++; $display("FAIL areset_outputs got enable=%b cyc=%b stb=%b exp 00/0/0", bus.enable, bus.wb_cyc_o, bus.wb_stb_o); end
    step();
    idle_all();
    rst = 1'b1;
    bus.req = 2'b11;
    step();
    checks++; if (bus.enable !== 2'b01) begin errors++; $display("FAIL areset_ptr enable=%b exp=01", bus.enable); end
    bus.req = 2'b00;
    step(3);
    bus.req = 2'b10;
    step();
    checks++; if (bus.enable !== 2'b10) begin errors++; $display("FAIL areset_req1 enable=%b exp=10", bus.enable); end
    idle_all();
    step(3);
  endtask

  initial begin
    rst = 1'b0;
    idle_all();
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_watchdog();
    test_err_pass();
    test_async_reset();
    checks++; if (exp_q.size() !== 0) begin
      errors++; $display("FAIL sb_leftover got=%0d pending exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/na_wb_arbiter.md
Name: na_wb_arbiter

Overview:
Shares the single Wishbone master port into the network interface between NUM_REQ network-adapter units (DI write bridges, read bridges). It uses their req/enable handshake. Each requester holds req for a whole packet transfer. The arbiter grants exactly one requester at a time in round-robin order and multiplexes the Wishbone signals to the NI. A watchdog terminates Wishbone cycles that are never acknowledged.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
NOC_FLIT_WIDTH, 32, Wishbone data width
TIMEOUT, 256, cycles a granted cycle may wait for ack/err before forced error (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester bus request, held for the whole packet
enable  out  NUM_REQ  per-requester grant, one-hot or zero, registered
s_adr_i  in  NUM_REQ*32  requester addresses, requester i at [32*i +: 32]
s_dat_i  in  NUM_REQ*NOC_FLIT_WIDTH  requester write data
s_we_i  in  NUM_REQ  requester write enables
s_stb_i  in  NUM_REQ  requester strobes
s_cyc_i  in  NUM_REQ  requester cycle signals
s_ack_o  out  NUM_REQ  ack routed to granted requester
s_err_o  out  NUM_REQ  err routed to granted requester (incl. watchdog error)
s_dat_o  out  NOC_FLIT_WIDTH  read data, broadcast to all requesters
wb_adr_o  out  32  to NI
wb_dat_o  out  NOC_FLIT_WIDTH  to NI
wb_we_o  out  1  to NI
wb_stb_o  out  1  to NI
wb_cyc_o  out  1  to NI
wb_ack_i  in  1  from NI
wb_err_i  in  1  from NI
wb_dat_i  in  NOC_FLIT_WIDTH  from NI
timeout  out  1  one-cycle pulse on watchdog expiry, registered

Behaviour:
- Reset (rst low, async):
  - state IDLE, enable=0, timeout=0, watchdog counter 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - All wb_*_o and s_ack_o/s_err_o are 0 while no grant.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any req bit is set, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register g = selection, enable[g]=1, go to GRANT.
  - Latency: req seen at edge t gives enable at t+1.
- GRANT:
  - Master outputs = requester g's s_*_i.
  - s_ack_o[g]=wb_ack_i, s_err_o[g]=wb_err_i. All other ack/err bits are 0.
  - s_dat_o=wb_dat_i at all times.
  - Requesters not granted are ignored, even if their cyc/stb are high.
- Exit from GRANT: when req[g]==0 and s_cyc_i[g]==0 in the same cycle.
  - enable cleared, pointer = (g+1) mod NUM_REQ, go to RELEASE.
  - req dropping while cyc is still high does not release; the grant holds until cyc falls.
- RELEASE: one cycle with enable=0 and the bus idle (wb_cyc_o=0), then IDLE.
  - Minimum gap between two grants is 2 cycles.
- Watchdog counter:
  - Counts while state is GRANT and s_cyc_i[g] & s_stb_i[g] is high and neither wb_ack_i nor wb_err_i is high.
  - Clears on ack, on err, or when stb is low.
  - Saturating width is clog2(TIMEOUT+1).
- Watchdog expiry (counter == TIMEOUT-1 with no ack/err that cycle):
  - s_err_o[g]=1 for that one cycle and wb_cyc_o/wb_stb_o forced to 0 in that cycle.
  - timeout pulses at the next edge; counter clears.
  - Grant is kept; the requester decides whether to release.
- Simultaneous events:
  - wb_ack_i and expiry in the same cycle: ack wins and no timeout is raised.
  - wb_ack_i and wb_err_i together are passed through unchanged.
- A new req from the granted requester in RELEASE is served only after a full IDLE arbitration, under normal round-robin.
- Reset mid-transfer: the grant is dropped immediately, outputs go to 0 asynchronously, and the pointer returns to 0.
- NUM_REQ=1: same FSM, pointer always 0.

Test Plan:
- Single requester: req[0] rises at cycle 5 -> enable[0]=1 at 6. Write adr 0x10, data 0xCAFE0001 reaches wb_*_o unchanged. After req and cyc drop, enable=0 and RELEASE lasts exactly 1 cycle.
- Contention: req=2'b11 from reset -> requester 0 granted first. After its release, requester 1 is granted at release+2. If req[0] is re-asserted meanwhile, it is granted only after requester 1 releases.
- Hold rule: requester 0 drops req while s_cyc_i[0]=1 for 3 more cycles -> enable[0] stays high until cyc falls. Requester 1's strobes never reach wb_stb_o.
- Watchdog, TIMEOUT=8: granted stb held with no ack -> s_err_o[0] high on the 8th waiting cycle and timeout pulses once. Ack arriving on cycle 8 instead gives no error.
- Error passthrough: wb_err_i asserted on the 2nd beat -> s_err_o[g] only, other requesters' err stays 0, grant is unchanged.
- Async reset with rst low mid-burst -> enable, wb_cyc_o and wb_stb_o go to 0 without a clock edge. After release, req=2'b10 grants requester 1 and req=2'b11 grants requester 0.
